// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, flag bit positions and the ALU stage states.
package cpu_pkg;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    ADC    = 4'd1,
    SUB    = 4'd2,
    SBC    = 4'd3,
    AND    = 4'd4,
    XOR    = 4'd5,
    OR     = 4'd6,
    CP     = 4'd7,
    CPL    = 4'd8,
    SCF    = 4'd9,
    CCF    = 4'd10,
    LD_A   = 4'd11,
    POP_AF = 4'd12,
    DAA    = 4'd13
  } alu_op_t;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Assemble a full F byte; the low nibble is architecturally always zero.
  function automatic logic [7:0] make_flags(input logic z, input logic n,
                                            input logic h, input logic c);
    return {z, n, h, c, 4'h0};
  endfunction

endpackage

// File: rtl/daa_calc.sv
// Decimal adjust of A after a BCD add/subtract, driven by the N/H/C flags.
module daa_calc
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [3:0] fin,
  output logic [7:0] aout,
  output logic [3:0] fout
);

  logic       n_flag;
  logic       lo_adj;
  logic       hi_adj;
  logic [7:0] corr;

  // After a subtract only the recorded H/C borrows drive the correction.
  always_comb begin
    n_flag = fin[FLAG_N-4];
    lo_adj = fin[FLAG_H-4] | (~n_flag & (a[3:0] > 4'd9));
    hi_adj = fin[FLAG_C-4] | (~n_flag & (a > 8'h99));
    corr   = {(hi_adj ? 4'h6 : 4'h0), (lo_adj ? 4'h6 : 4'h0)};
    aout   = n_flag ? (a - corr) : (a + corr);
    fout   = {(aout == 8'h00), n_flag, 1'b0, hi_adj};
  end

endmodule

// File: rtl/af_alu_unit.sv
// Accumulator/flag execution stage holding the architectural A and F registers.
// Build option: define AF_ALU_DAA_EN to instantiate daa_calc and execute DAA.
module af_alu_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] A_RESET = 8'h01,
  parameter logic [7:0] F_RESET = 8'hB0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  alu_op_t    op,
  input  logic [7:0] op_b,
  input  logic [7:0] op_f,
  output logic [7:0] a_out,
  output logic [7:0] f_out,
  output logic       done
);

  alu_state_t state_q, state_d;
  alu_op_t    op_q;
  logic [7:0] b_q;
  logic [3:0] fsrc_q;
  logic [7:0] a_q, a_d;
  logic [7:0] f_q, f_d;
  logic       accept;

  logic       sub_mode;
  logic       cin;
  logic [7:0] b_eff;
  logic [8:0] sum;
  logic       half;
  logic       carry;
  logic [7:0] logic_r;

  logic unused_fsrc_lo;
  assign unused_fsrc_lo = ^op_f[3:0];

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = op_ready & op_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      op_q    <= ADD;
      b_q     <= 8'h00;
      fsrc_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op;
        b_q    <= op_b;
        fsrc_q <= op_f[7:4];
      end
    end
  end

  // Subtraction reuses the adder as A + ~B + cin; carries then invert into borrows.
  always_comb begin
    sub_mode = (op_q == SUB) || (op_q == SBC) || (op_q == CP);
    case (op_q)
      ADC:     cin = f_q[FLAG_C];
      SUB, CP: cin = 1'b1;
      SBC:     cin = ~f_q[FLAG_C];
      default: cin = 1'b0;
    endcase
    b_eff = sub_mode ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {8'd0, cin};
    half  = sum[4] ^ a_q[4] ^ b_eff[4] ^ sub_mode;
    carry = sum[8] ^ sub_mode;
    case (op_q)
      AND:     logic_r = a_q & b_q;
      XOR:     logic_r = a_q ^ b_q;
      default: logic_r = a_q | b_q;
    endcase
  end

`ifdef AF_ALU_DAA_EN
  logic [7:0] daa_a;
  logic [3:0] daa_f;

  daa_calc u_daa (
    .a    (a_q),
    .fin  (f_q[7:4]),
    .aout (daa_a),
    .fout (daa_f)
  );
`endif

  always_comb begin
    a_d = a_q;
    f_d = f_q;
    if (state_q == ST_EXEC) begin
      case (op_q)
        ADD, ADC, SUB, SBC: begin
          a_d = sum[7:0];
          f_d = make_flags(sum[7:0] == 8'h00, sub_mode, half, carry);
        end
        CP: f_d = make_flags(sum[7:0] == 8'h00, 1'b1, half, carry);
        AND: begin
          a_d = logic_r;
          f_d = make_flags(logic_r == 8'h00, 1'b0, 1'b1, 1'b0);
        end
        OR, XOR: begin
          a_d = logic_r;
          f_d = make_flags(logic_r == 8'h00, 1'b0, 1'b0, 1'b0);
        end
        CPL: begin
          a_d = ~a_q;
          f_d = make_flags(f_q[FLAG_Z], 1'b1, 1'b1, f_q[FLAG_C]);
        end
        SCF: f_d = make_flags(f_q[FLAG_Z], 1'b0, 1'b0, 1'b1);
        CCF: f_d = make_flags(f_q[FLAG_Z], 1'b0, 1'b0, ~f_q[FLAG_C]);
        LD_A: a_d = b_q;
        POP_AF: begin
          a_d = b_q;
          f_d = {fsrc_q, 4'h0};
        end
`ifdef AF_ALU_DAA_EN
        DAA: begin
          a_d = daa_a;
          f_d = {daa_f, 4'h0};
        end
`endif
        default: ;
      endcase
    end
  end

  // A reset anywhere in the sequence drops the pending writeback with the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q <= A_RESET;
      f_q <= {F_RESET[7:4], 4'h0};
    end else begin
      a_q <= a_d;
      f_q <= f_d;
    end
  end

  assign a_out = a_q;
  assign f_out = f_q;

endmodule

// File: tb/tb_af_alu_unit.sv
// Randomized self-checking bench for af_alu_unit against a cycle-numbered reference model.
// Honours AF_ALU_DAA_EN the same way as the design.
module tb_af_alu_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       op_valid;
  logic       op_ready;
  alu_op_t    op;
  logic [7:0] op_b;
  logic [7:0] op_f;
  logic [7:0] a_out;
  logic [7:0] f_out;
  logic       done;

  int total = 0;
  int bad   = 0;

  af_alu_unit dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .op_b     (op_b),
    .op_f     (op_f),
    .a_out    (a_out),
    .f_out    (f_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference result of one operation from plain integer arithmetic.
  function automatic logic [15:0] aluModel(input logic [3:0] opc, input int a, input int f,
                                           input int b, input int fs);
    int r, z, n, h, c, ci, na, nf;
    ci = (f >> 4) & 1;
    na = a;
    nf = f;
    n = 0; h = 0; c = 0;
    case (alu_op_t'(opc))
      ADD, ADC: begin
        if (alu_op_t'(opc) == ADD) ci = 0;
        r = a + b + ci;
        h = (((a & 15) + (b & 15) + ci) > 15) ? 1 : 0;
        c = (r > 255) ? 1 : 0;
        na = r & 255;
        nf = ((na == 0) ? 128 : 0) | (h << 5) | (c << 4);
      end
      SUB, SBC, CP: begin
        if (alu_op_t'(opc) != SBC) ci = 0;
        r = a - b - ci;
        h = (((a & 15) - (b & 15) - ci) < 0) ? 1 : 0;
        c = (r < 0) ? 1 : 0;
        if (alu_op_t'(opc) != CP) na = r & 255;
        nf = (((r & 255) == 0) ? 128 : 0) | 64 | (h << 5) | (c << 4);
      end
      AND: begin na = a & b; nf = ((na == 0) ? 128 : 0) | 32; end
      OR:  begin na = a | b; nf = (na == 0) ? 128 : 0; end
      XOR: begin na = a ^ b; nf = (na == 0) ? 128 : 0; end
      CPL: begin na = (~a) & 255; nf = f | 96; end
      SCF: nf = (f & 128) | 16;
      CCF: nf = (f & 128) | ((~f) & 16);
      LD_A: na = b;
      POP_AF: begin na = b; nf = fs & 240; end
`ifdef AF_ALU_DAA_EN
      DAA: begin
        n = (f >> 6) & 1; h = (f >> 5) & 1; c = (f >> 4) & 1;
        r = a;
        if (n == 0) begin
          if (c == 1 || r > 153) begin r = r + 96; c = 1; end
          if (h == 1 || (r & 15) > 9) r = r + 6;
        end else begin
          if (c == 1) r = r - 96;
          if (h == 1) r = r - 6;
        end
        na = r & 255;
        nf = ((na == 0) ? 128 : 0) | (n << 6) | (c << 4);
      end
`endif
      default: ;
    endcase
    return {8'(na), 8'(nf)};
  endfunction

  logic [7:0]  mA, mF;
  int          cyc, acceptAt;
  logic        busy;
  logic [15:0] pendRes;
  logic        expReady, expDone;

  // Model timeline: accept at cycle N, result visible and done at N+2, ready again at N+3.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mA <= 8'h01; mF <= 8'hB0;
      cyc <= 0; acceptAt <= 0; busy <= 1'b0; pendRes <= 16'h0;
    end else begin
      cyc <= cyc + 1;
      if (!busy && op_valid) begin
        busy     <= 1'b1;
        acceptAt <= cyc;
        pendRes  <= aluModel(op, int'(mA), int'(mF), int'(op_b), int'(op_f));
      end
      if (busy && cyc == acceptAt + 1) {mA, mF} <= pendRes;
      if (busy && cyc == acceptAt + 2) busy <= 1'b0;
    end
  end

  assign expReady = !busy;
  assign expDone  = busy && (cyc == acceptAt + 2);

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("model a_out", a_out, mA);
    checkVal("model f_out", f_out, mF);
    checkVal("model op_ready", 8'(op_ready), 8'(expReady));
    checkVal("model done", 8'(done), 8'(expDone));
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
  endtask

  // Issue one request from idle and pin the writeback exactly two cycles later.
  task automatic applyStimulus(input alu_op_t o, input logic [7:0] b, input logic [7:0] f,
                               input logic [7:0] expA, input logic [7:0] expF);
    op_valid = 1'b1; op = o; op_b = b; op_f = f;
    stepCycle();
    op_valid = 1'b0; op_b = 8'hA5; op_f = 8'h5A;
    stepCycle();
    checkVal("pin done", 8'(done), 8'h01);
    checkVal("pin a_out", a_out, expA);
    checkVal("pin f_out", f_out, expF);
    stepCycle();
  endtask

  initial begin
    int accepts, dones, doneMask;
    n_rst = 1'b0; op_valid = 1'b0; op = ADD; op_b = 8'h00; op_f = 8'h00;
    repeat (2) stepCycle();
    checkVal("reset a_out", a_out, 8'h01);
    checkVal("reset f_out", f_out, 8'hB0);
    checkVal("reset op_ready", 8'(op_ready), 8'h01);
    checkVal("reset done", 8'(done), 8'h00);
    n_rst = 1'b1;
    stepCycle();

    applyStimulus(POP_AF, 8'h12, 8'hFF, 8'h12, 8'hF0);

    applyStimulus(POP_AF, 8'h50, 8'h00, 8'h50, 8'h00);
    applyStimulus(ADD, 8'h60, 8'h00, 8'hB0, 8'h00);
`ifdef AF_ALU_DAA_EN
    applyStimulus(DAA, 8'h00, 8'h00, 8'h10, 8'h10);
    applyStimulus(POP_AF, 8'h10, 8'h00, 8'h10, 8'h00);
    applyStimulus(SUB, 8'h01, 8'h00, 8'h0F, 8'h60);
    applyStimulus(DAA, 8'h00, 8'h00, 8'h09, 8'h40);
`else
    applyStimulus(DAA, 8'h00, 8'h00, 8'hB0, 8'h00);
    applyStimulus(POP_AF, 8'h10, 8'h00, 8'h10, 8'h00);
    applyStimulus(SUB, 8'h01, 8'h00, 8'h0F, 8'h60);
`endif

    applyStimulus(POP_AF, 8'hFF, 8'h10, 8'hFF, 8'h10);
    applyStimulus(ADC, 8'h00, 8'h00, 8'h00, 8'hB0);
    applyStimulus(CP, 8'h01, 8'h00, 8'h00, 8'h70);
    applyStimulus(SBC, 8'h00, 8'h00, 8'hFF, 8'h70);
    applyStimulus(alu_op_t'(4'd15), 8'h33, 8'h00, 8'hFF, 8'h70);

    // Held request: accepts only at relative cycles 0 and 3, done at 2 and 5.
    applyStimulus(POP_AF, 8'h00, 8'h00, 8'h00, 8'h00);
    accepts = 0; dones = 0; doneMask = 0;
    op_valid = 1'b1; op = ADD; op_b = 8'h01; op_f = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) op_valid = 1'b0;
      if (op_ready && op_valid) accepts++;
      stepCycle();
      if (done) begin dones++; doneMask |= (1 << (i + 1)); end
    end
    checkVal("handshake accepts", 8'(accepts), 8'd2);
    checkVal("handshake dones", 8'(dones), 8'd2);
    checkVal("handshake done cycles", 8'(doneMask), 8'b0010_0100);
    checkVal("handshake final a", a_out, 8'h02);

    applyStimulus(POP_AF, 8'h33, 8'h00, 8'h33, 8'h00);
    op_valid = 1'b1; op = ADD; op_b = 8'h05;
    stepCycle();
    n_rst = 1'b0; op_valid = 1'b0;
    stepCycle();
    checkVal("exec reset done", 8'(done), 8'h00);
    checkVal("exec reset a_out", a_out, 8'h01);
    checkVal("exec reset f_out", f_out, 8'hB0);
    n_rst = 1'b1;
    stepCycle();
    checkVal("exec reset no late done", 8'(done), 8'h00);

    for (int i = 0; i < 600; i++) begin
      if (!n_rst) n_rst = 1'b1;
      else if ($urandom_range(0, 79) == 0) n_rst = 1'b0;
      op_valid = ($urandom_range(0, 2) != 0);
      op       = alu_op_t'(4'($urandom_range(0, 15)));
      op_b     = 8'($urandom);
      op_f     = 8'($urandom);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
